// File: rtl/axi_slave_ram_pkg.sv
// ---------------------------------------------------------------------------
// axi_slave_ram_pkg
// Shared types and constants for the AXI burst RAM slave.
//   wr_state_e  : write-channel FSM states
//   rd_state_e  : read-channel FSM states
//   RESP_OKAY / RESP_SLVERR : AXI response codes used on B and R
// ---------------------------------------------------------------------------
package axi_slave_ram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi_slave_ram_dpram.sv
// ---------------------------------------------------------------------------
// axi_slave_ram_dpram
// Simple dual-port RAM: one byte-enabled write port, one read port with a
// registered output (data appears the cycle after rd_en). A read and a write
// to the same word in the same cycle return the old contents.
// Ports:
//   clk                 : clock
//   wr_en/wr_addr/wr_data/wr_be : write port, wr_be has one bit per byte
//   rd_en/rd_addr       : read request
//   rd_data             : registered read data, holds between reads
// No reset: contents and the output register survive reset.
// ---------------------------------------------------------------------------
module axi_slave_ram_dpram #(
  parameter int AW = 10,
  parameter int DW = 128
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic [DW/8-1:0] wr_be,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [DW-1:0]   rd_data
);

  localparam int NB = DW / 8;

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_data_d;
  logic [DW-1:0] rd_data_q;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) begin
          mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_slave_ram.sv
// ---------------------------------------------------------------------------
// axi_slave_ram
// AXI4 slave backed by an on-chip RAM. INCR bursts of 1-256 full-width beats;
// size/burst/cache/prot/qos are not used. Word index is taken from the address
// bits just above the byte offset and wraps modulo the RAM depth.
//
// Write FSM                           Read FSM
//   state  | meaning                    state   | meaning
//   W_IDLE | AWREADY=1, wait for AW     R_IDLE  | ARREADY=1, wait for AR
//   W_DATA | WREADY=1, accept beats     R_BURST | issue RAM reads, drain
//   W_RESP | BVALID=1 until BREADY               skid buffer to R channel
//
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET : clock, synchronous active-high reset
//   AW*, W*, B*               : write address / data / response channels
//   AR*, R*                   : read address / data channels
//
// Build option: define AXI_SLAVE_RAM_WSTRB_EN to honour WSTRB byte enables;
// otherwise every accepted beat writes the whole word.
// ---------------------------------------------------------------------------
module axi_slave_ram
  import axi_slave_ram_pkg::*;
#(
  parameter int S_AXI_ID_WIDTH   = 16,
  parameter int S_AXI_ADDR_WIDTH = 32,
  parameter int S_AXI_DATA_WIDTH = 128,
  parameter int MEM_AW           = 10
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  // write address
  input  logic [S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                    S_AXI_AWLEN,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  // write data
  input  logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                          S_AXI_WLAST,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  // write response
  output logic [S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  // read address
  input  logic [S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  // read data
  output logic [S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY
);

  localparam int STRB_W = S_AXI_DATA_WIDTH / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int DW     = S_AXI_DATA_WIDTH;
  localparam int IW     = S_AXI_ID_WIDTH;

  // -------------------------------------------------------------------------
  // RAM
  // -------------------------------------------------------------------------
  logic              ram_we;
  logic [STRB_W-1:0] ram_be;
  logic              ram_re;
  logic [DW-1:0]     ram_rdata;

  logic [MEM_AW-1:0] wr_idx_q, wr_idx_d;
  logic [MEM_AW-1:0] rd_idx_q, rd_idx_d;

  axi_slave_ram_dpram #(
    .AW (MEM_AW),
    .DW (DW)
  ) u_dpram (
    .clk     (S_AXI_ACLK),
    .wr_en   (ram_we),
    .wr_addr (wr_idx_q),
    .wr_data (S_AXI_WDATA),
    .wr_be   (ram_be),
    .rd_en   (ram_re),
    .rd_addr (rd_idx_q),
    .rd_data (ram_rdata)
  );

`ifdef AXI_SLAVE_RAM_WSTRB_EN
  assign ram_be = S_AXI_WSTRB;
  logic unused_in;
  assign unused_in = ^{S_AXI_AWADDR, S_AXI_ARADDR};
`else
  assign ram_be = '1;
  logic unused_in;
  assign unused_in = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WSTRB};
`endif

  // -------------------------------------------------------------------------
  // Write channel
  // -------------------------------------------------------------------------
  wr_state_e         wr_state_q, wr_state_d;
  logic [IW-1:0]     wr_id_q, wr_id_d;
  logic [7:0]        wr_left_q, wr_left_d;   // beats remaining after this one
  logic              wr_err_q, wr_err_d;     // sticky WLAST misplacement
  logic              wr_last_beat;

  assign wr_last_beat = (wr_left_q == 8'd0);

  always_comb begin
    wr_state_d = wr_state_q;
    wr_id_d    = wr_id_q;
    wr_idx_d   = wr_idx_q;
    wr_left_d  = wr_left_q;
    wr_err_d   = wr_err_q;
    ram_we     = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (S_AXI_AWVALID) begin
          wr_id_d    = S_AXI_AWID;
          wr_idx_d   = S_AXI_AWADDR[OFF +: MEM_AW];
          wr_left_d  = S_AXI_AWLEN;
          wr_err_d   = 1'b0;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (S_AXI_WVALID) begin
          ram_we   = 1'b1;
          wr_idx_d = wr_idx_q + MEM_AW'(1);
          // burst length is decided by AWLEN alone; WLAST only flags errors
          wr_err_d = wr_err_q | (S_AXI_WLAST ^ wr_last_beat);
          if (wr_last_beat) begin
            wr_state_d = W_RESP;
          end else begin
            wr_left_d = wr_left_q - 8'd1;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      wr_state_q <= W_IDLE;
      wr_id_q    <= '0;
      wr_idx_q   <= '0;
      wr_left_q  <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_id_q    <= wr_id_d;
      wr_idx_q   <= wr_idx_d;
      wr_left_q  <= wr_left_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign S_AXI_AWREADY = (wr_state_q == W_IDLE);
  assign S_AXI_WREADY  = (wr_state_q == W_DATA);
  assign S_AXI_BVALID  = (wr_state_q == W_RESP);
  assign S_AXI_BID     = wr_id_q;
  assign S_AXI_BRESP   = (S_AXI_BVALID && wr_err_q) ? RESP_SLVERR : RESP_OKAY;

  // -------------------------------------------------------------------------
  // Read channel
  // RAM reads are issued one per cycle while the skid buffer plus the read
  // in flight can still absorb the data; the buffer then feeds R directly.
  // -------------------------------------------------------------------------
  rd_state_e            rd_state_q, rd_state_d;
  logic [IW-1:0]        rd_id_q, rd_id_d;
  logic [7:0]           rd_left_q, rd_left_d;     // reads still to issue - 1
  logic                 rd_done_q, rd_done_d;     // all reads of burst issued
  logic                 rd_pend_q, rd_pend_d;     // RAM output valid this cycle
  logic                 rd_pend_last_q, rd_pend_last_d;
  logic [1:0][DW-1:0]   buf_data_q, buf_data_d;   // entry 0 is the head
  logic [1:0]           buf_last_q, buf_last_d;
  logic [1:0]           buf_cnt_q, buf_cnt_d;
  logic                 r_pop;
  logic [1:0]           occ;

  assign r_pop = (buf_cnt_q != 2'd0) && S_AXI_RREADY;
  // entries the buffer will hold once the in-flight read lands
  assign occ   = buf_cnt_q + 2'(rd_pend_q) - 2'(r_pop);

  always_comb begin
    rd_state_d     = rd_state_q;
    rd_id_d        = rd_id_q;
    rd_idx_d       = rd_idx_q;
    rd_left_d      = rd_left_q;
    rd_done_d      = rd_done_q;
    ram_re         = 1'b0;
    buf_data_d     = buf_data_q;
    buf_last_d     = buf_last_q;
    buf_cnt_d      = buf_cnt_q;

    case (rd_state_q)
      R_IDLE: begin
        if (S_AXI_ARVALID) begin
          rd_id_d    = S_AXI_ARID;
          rd_idx_d   = S_AXI_ARADDR[OFF +: MEM_AW];
          rd_left_d  = S_AXI_ARLEN;
          rd_done_d  = 1'b0;
          rd_state_d = R_BURST;
        end
      end
      R_BURST: begin
        if (!rd_done_q && (occ < 2'd2)) begin
          ram_re   = 1'b1;
          rd_idx_d = rd_idx_q + MEM_AW'(1);
          if (rd_left_q == 8'd0) begin
            rd_done_d = 1'b1;
          end else begin
            rd_left_d = rd_left_q - 8'd1;
          end
        end
        if (r_pop && buf_last_q[0]) begin
          rd_state_d = R_IDLE;
        end
      end
    endcase

    rd_pend_d      = ram_re;
    rd_pend_last_d = ram_re && (rd_left_q == 8'd0);

    if (r_pop) begin
      buf_data_d[0] = buf_data_q[1];
      buf_last_d[0] = buf_last_q[1];
      buf_cnt_d     = buf_cnt_q - 2'd1;
    end
    if (rd_pend_q) begin
      buf_data_d[buf_cnt_d[0]] = ram_rdata;
      buf_last_d[buf_cnt_d[0]] = rd_pend_last_q;
      buf_cnt_d                = buf_cnt_d + 2'd1;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rd_state_q     <= R_IDLE;
      rd_id_q        <= '0;
      rd_idx_q       <= '0;
      rd_left_q      <= '0;
      rd_done_q      <= 1'b0;
      rd_pend_q      <= 1'b0;
      rd_pend_last_q <= 1'b0;
      buf_data_q     <= '0;
      buf_last_q     <= '0;
      buf_cnt_q      <= '0;
    end else begin
      rd_state_q     <= rd_state_d;
      rd_id_q        <= rd_id_d;
      rd_idx_q       <= rd_idx_d;
      rd_left_q      <= rd_left_d;
      rd_done_q      <= rd_done_d;
      rd_pend_q      <= rd_pend_d;
      rd_pend_last_q <= rd_pend_last_d;
      buf_data_q     <= buf_data_d;
      buf_last_q     <= buf_last_d;
      buf_cnt_q      <= buf_cnt_d;
    end
  end

  assign S_AXI_ARREADY = (rd_state_q == R_IDLE);
  assign S_AXI_RVALID  = (buf_cnt_q != 2'd0);
  assign S_AXI_RDATA   = buf_data_q[0];
  assign S_AXI_RLAST   = S_AXI_RVALID && buf_last_q[0];
  assign S_AXI_RID     = rd_id_q;
  assign S_AXI_RRESP   = RESP_OKAY;

endmodule
